// File: rtl/shift_load_pkg.sv
// Shared sel codes, direction constants and FSM states for the shift-load
// sequencer and the bidirectional shift register it drives.
package shift_load_pkg;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LEFT  = 2'b01;
    localparam logic [1:0] SEL_RIGHT = 2'b10;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bidirection_shiftregister.sv
// Downstream bidirectional shift register: left shifts take d1 into the LSB,
// right shifts take d0 into the MSB, anything else holds.
module bidirection_shiftregister
    import shift_load_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic             d0,
    input  logic             d1,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

    generate
        if (WIDTH == 1) begin : g_one
            assign shl = d1;
            assign shr = d0;
        end else begin : g_multi
            assign shl = {q[WIDTH-2:0], d1};
            assign shr = {d0, q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            case (sel)
                SEL_LEFT:  q <= shl;
                SEL_RIGHT: q <= shr;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_load_sequencer.sv
// Accepts a parallel word over valid/ready and serialises it onto the
// sel/d0/d1 inputs of a bidirectional shift register, then pulses done.
module shift_load_sequencer
    import shift_load_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    output logic [1:0]       sel,
    output logic             d0,
    output logic             d1,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word;
    logic             dir;

    logic [CW-1:0]    next_cnt;
    logic [CW-1:0]    next_idx;
    logic             next_bit;
    logic             first_bit;

    assign in_ready = (state == IDLE);

    // Outputs are registered, so each edge prepares the bit for the following cycle.
    always_comb begin
        next_cnt  = cnt + 1'b1;
        next_idx  = (dir == DIR_LEFT) ? (LAST - next_cnt) : next_cnt;
        next_bit  = word[next_idx];
        first_bit = (in_dir == DIR_LEFT) ? in_data[WIDTH-1] : in_data[0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            word  <= '0;
            dir   <= DIR_RIGHT;
            sel   <= SEL_HOLD;
            d0    <= 1'b0;
            d1    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sel  <= SEL_HOLD;
                    d0   <= 1'b0;
                    d1   <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (in_valid) begin
                        word  <= in_data;
                        dir   <= in_dir;
                        cnt   <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                        sel   <= (in_dir == DIR_LEFT) ? SEL_LEFT : SEL_RIGHT;
                        d0    <= (in_dir == DIR_RIGHT) & first_bit;
                        d1    <= (in_dir == DIR_LEFT) & first_bit;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                        sel   <= SEL_HOLD;
                        d0    <= 1'b0;
                        d1    <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= next_cnt;
                        d0  <= (dir == DIR_RIGHT) & next_bit;
                        d1  <= (dir == DIR_LEFT) & next_bit;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    sel   <= SEL_HOLD;
                    d0    <= 1'b0;
                    d1    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Bench driving shift_load_sequencer into bidirection_shiftregister and
// checking the serial stream, handshake and final q cycle by cycle.
module tb_shift_load_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_dir;
    logic [1:0] sel;
    logic       d0;
    logic       d1;
    logic       busy;
    logic       done;
    logic [3:0] q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic [0:3] stream;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        logic       d0;
        logic       d1;
        logic       done;
        logic       busy;
        logic       ready;
        logic       chkq;
        logic [3:0] q;
    } exp_t;

    exp_t expq[$];
    vec_t vectors[6];

    shift_load_sequencer #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dir   (in_dir),
        .sel      (sel),
        .d0       (d0),
        .d1       (d1),
        .busy     (busy),
        .done     (done)
    );

    bidirection_shiftregister #(.WIDTH(4)) downstream (
        .clk (clk),
        .rst (rst),
        .sel (sel),
        .d0  (d0),
        .d1  (d1),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
        end else begin
            e = '{sel: 2'b00, d0: 1'b0, d1: 1'b0, done: 1'b0, busy: 1'b0,
                  ready: 1'b1, chkq: 1'b0, q: 4'h0};
        end
        check("sel", 32'(sel), 32'(e.sel));
        check("d0", 32'(d0), 32'(e.d0));
        check("d1", 32'(d1), 32'(e.d1));
        check("done", 32'(done), 32'(e.done));
        check("busy", 32'(busy), 32'(e.busy));
        check("in_ready", 32'(in_ready), 32'(e.ready));
        if (e.chkq) check("q", 32'(q), 32'(e.q));
    endtask

    task automatic check_reset_state();
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_d0", 32'(d0), 32'h0);
        check("rst_d1", 32'(d1), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_q", 32'(q), 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic drain();
        while (expq.size() > 0) tick();
    endtask

    // Offers a word in the current cycle (cycle 0) and queues cycles 1..6.
    task automatic apply_stimulus(input logic [3:0] data, input logic dir,
                                  input logic [0:3] stream, input logic hold_valid);
        exp_t e;
        check("ready_at_offer", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        in_data  = data;
        in_dir   = dir;
        for (int k = 0; k < 4; k++) begin
            e = '{sel: dir ? 2'b01 : 2'b10,
                  d0: dir ? 1'b0 : stream[k],
                  d1: dir ? stream[k] : 1'b0,
                  done: 1'b0, busy: 1'b1, ready: 1'b0, chkq: 1'b0, q: 4'h0};
            expq.push_back(e);
        end
        expq.push_back('{sel: 2'b00, d0: 1'b0, d1: 1'b0, done: 1'b1, busy: 1'b1,
                         ready: 1'b0, chkq: 1'b1, q: data});
        expq.push_back('{sel: 2'b00, d0: 1'b0, d1: 1'b0, done: 1'b0, busy: 1'b0,
                         ready: 1'b1, chkq: 1'b1, q: data});
        tick();
        in_valid = hold_valid;
    endtask

    initial begin
        vectors[0] = '{data: 4'b1011, dir: 1'b0, stream: 4'b1101};
        vectors[1] = '{data: 4'b0110, dir: 1'b1, stream: 4'b0110};
        vectors[2] = '{data: 4'b1000, dir: 1'b0, stream: 4'b0001};
        vectors[3] = '{data: 4'b0001, dir: 1'b1, stream: 4'b0001};
        vectors[4] = '{data: 4'b1110, dir: 1'b1, stream: 4'b1110};
        vectors[5] = '{data: 4'b0011, dir: 1'b0, stream: 4'b1100};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        in_dir   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_reset_state();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("release_ready", 32'(in_ready), 32'h1);
        tick();
        tick();

        $display("[TB] table-driven loads");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vectors[i].data, vectors[i].dir, vectors[i].stream, 1'b0);
            drain();
        end

        $display("[TB] reset while idle");
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_reset_state();
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("release_ready_idle", 32'(in_ready), 32'h1);
        tick();

        $display("[TB] inputs ignored while busy");
        apply_stimulus(4'b1011, 1'b0, 4'b1101, 1'b1);
        in_data = 4'b1111;
        in_dir  = 1'b1;
        repeat (5) tick();
        apply_stimulus(4'b1111, 1'b0, 4'b1111, 1'b0);
        drain();

        $display("[TB] reset during transfer");
        apply_stimulus(4'b1011, 1'b0, 4'b1101, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_reset_state();
        expq.delete();
        #2;
        rst = 1'b1;
        repeat (3) tick();
        check("aborted_q", 32'(q), 32'h0);
        apply_stimulus(4'b0101, 1'b0, 4'b1010, 1'b0);
        drain();

        $display("[TB] back-to-back words");
        apply_stimulus(4'b1000, 1'b0, 4'b0001, 1'b1);
        in_data = 4'b0001;
        in_dir  = 1'b1;
        repeat (5) tick();
        apply_stimulus(4'b0001, 1'b1, 4'b0001, 1'b0);
        drain();
        tick();
        check("final_q", 32'(q), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
